// File: rtl/serial_pattern_pkg.sv
// rtl/serial_pattern_pkg.sv - shared types and defaults for the serial pattern scanner
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FLUSH  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_RST_PAT = 4'b1011;

    // Step counter must also hold DATA_W so FLUSH can address mask bit 0.
    function automatic int step_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/serial_pattern_scanner_if.sv
// rtl/serial_pattern_scanner_if.sv - word-in / result-out handshake bundle
interface serial_pattern_scanner_if
    import serial_pattern_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(DATA_W + 1)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic [DATA_W-1:0] out_mask;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, out_mask
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, out_mask
    );
endinterface

// File: rtl/moore_pattern_det.sv
// rtl/moore_pattern_det.sv - bit-serial fixed-length pattern detector with registered hit
module moore_pattern_det
    import serial_pattern_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);
    localparam int VC_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W:0]   hist_ext;
    logic [VC_W-1:0]  vcnt_q;
    logic [VC_W-1:0]  vcnt_next;
    logic             match;

    always_comb begin
        hist_ext  = {hist_q, bit_in};
        hist_next = hist_ext[PAT_W-1:0];
        vcnt_next = (vcnt_q == VC_W'(PAT_W)) ? vcnt_q : vcnt_q + VC_W'(1);
        match     = (vcnt_next == VC_W'(PAT_W)) && (hist_next == pattern);
    end

    // Without overlap only the valid count restarts; stale history bits never
    // satisfy the compare until PAT_W fresh bits have arrived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            vcnt_q <= '0;
            hit    <= 1'b0;
        end else if (clear) begin
            hist_q <= '0;
            vcnt_q <= '0;
            hit    <= 1'b0;
        end else if (shift_en) begin
            hist_q <= hist_next;
            vcnt_q <= (match && !overlap) ? '0 : vcnt_next;
            hit    <= match;
        end else begin
            hit    <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_pattern_scanner.sv
// rtl/serial_pattern_scanner.sv - word controller sequencing the serial pattern detector
module serial_pattern_scanner
    import serial_pattern_pkg::*;
#(
    parameter int               DATA_W  = DEF_DATA_W,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter int               CNT_W   = $clog2(DATA_W + 1)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [PAT_W-1:0]        cfg_pattern,
    input  logic                    cfg_overlap,
    serial_pattern_scanner_if.slave bus,
    output logic                    a_out,
    output logic                    bit_valid,
    output logic                    hit
);
    localparam int STEP_W = step_w(DATA_W);

    state_t            state_q;
    state_t            state_next;
    logic [PAT_W-1:0]  pattern_q;
    logic              overlap_q;
    logic [DATA_W-1:0] word_q;
    logic [STEP_W-1:0] step_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] hit_onehot;
    logic              accept;
    logic              record;
    logic              shift_en;
    logic              idle_st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (step_q == STEP_W'(DATA_W - 1)) state_next = FLUSH;
            FLUSH:   state_next = REPORT;
            REPORT:  if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // in_ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        idle_st       = (state_q == IDLE);
        shift_en      = (state_q == SHIFT);
        bit_valid     = shift_en;
        bus.out_valid = (state_q == REPORT);
        bus.in_ready  = idle_st & rst;
        a_out         = shift_en & word_q[DATA_W-1];
    end

    assign accept = idle_st && bus.in_valid;
    assign record = hit && ((state_q == SHIFT) || (state_q == FLUSH));

    // A hit seen now belongs to the previous step, i.e. word bit DATA_W-step.
    always_comb begin
        hit_onehot = '0;
        for (int k = 0; k < DATA_W; k++) begin
            if (k == DATA_W - int'(step_q)) hit_onehot[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= RST_PAT;
            overlap_q <= 1'b1;
            word_q    <= '0;
            step_q    <= '0;
            count_q   <= '0;
            mask_q    <= '0;
        end else begin
            if (cfg_we && idle_st) begin
                pattern_q <= cfg_pattern;
                overlap_q <= cfg_overlap;
            end
            if (accept) begin
                word_q  <= bus.in_data;
                step_q  <= '0;
                count_q <= '0;
                mask_q  <= '0;
            end else if (shift_en) begin
                word_q  <= word_q << 1;
                step_q  <= step_q + STEP_W'(1);
            end
            if (record) begin
                count_q <= count_q + CNT_W'(1);
                mask_q  <= mask_q | hit_onehot;
            end
        end
    end

    assign bus.out_count = count_q;
    assign bus.out_mask  = mask_q;

    moore_pattern_det #(
        .PAT_W (PAT_W)
    ) u_det (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .shift_en (shift_en),
        .bit_in   (a_out),
        .pattern  (pattern_q),
        .overlap  (overlap_q),
        .hit      (hit)
    );

endmodule

// File: tb/tb_serial_pattern_scanner.sv
// tb/tb_serial_pattern_scanner.sv - self-checking bench for serial_pattern_scanner
module tb_serial_pattern_scanner;
    localparam int DW = 8;
    localparam int PW = 4;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [PW-1:0] cfg_pattern;
    logic          cfg_overlap;
    logic          a_out;
    logic          bit_valid;
    logic          hit;

    int            checks;
    int            errors;
    logic [PW-1:0] cur_pat;
    logic          cur_ov;
    logic [31:0]   got_count;
    logic [31:0]   got_mask;

    serial_pattern_scanner_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    serial_pattern_scanner #(
        .DATA_W  (DW),
        .PAT_W   (PW),
        .RST_PAT (4'b1011),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .bus         (bus),
        .a_out       (a_out),
        .bit_valid   (bit_valid),
        .hit         (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sliding window of the most recent bits; a non-overlapping hit empties it.
    function automatic void model(input logic [DW-1:0] w, input logic [PW-1:0] p, input logic ov,
                                  output int cnt, output logic [DW-1:0] mask,
                                  output logic [DW-1:0] match);
        bit win[$];
        logic [PW-1:0] val;
        cnt   = 0;
        mask  = '0;
        match = '0;
        for (int i = 0; i < DW; i++) begin
            win.push_back(w[DW-1-i]);
            if (win.size() > PW) void'(win.pop_front());
            if (win.size() == PW) begin
                for (int j = 0; j < PW; j++) val[PW-1-j] = win[j];
                if (val == p) begin
                    cnt++;
                    mask[DW-1-i] = 1'b1;
                    match[i]     = 1'b1;
                    if (!ov) win.delete();
                end
            end
        end
    endfunction

    task automatic scan(input logic [DW-1:0] w, input bit do_cfg, input logic [PW-1:0] cp,
                        input logic co, input bit mid_cfg, input int hold);
        int            exp_cnt;
        logic [DW-1:0] exp_mask;
        logic [DW-1:0] exp_match;
        logic          exp_hit;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        if (do_cfg) begin
            cfg_we      = 1'b1;
            cfg_pattern = cp;
            cfg_overlap = co;
            cur_pat     = cp;
            cur_ov      = co;
        end
        model(w, cur_pat, cur_ov, exp_cnt, exp_mask, exp_match);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cfg_we       = 1'b0;
        for (int c = 1; c <= DW + 1; c++) begin
            exp_hit = (c >= 2) ? exp_match[c-2] : 1'b0;
            chk("busy_out_valid", 32'(bus.out_valid), 32'd0);
            chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hit_lag", 32'(hit), 32'(exp_hit));
            if (c <= DW) begin
                chk("shift_bit_valid", 32'(bit_valid), 32'd1);
                chk("shift_a_out", 32'(a_out), 32'(w[DW-c]));
            end else begin
                chk("flush_bit_valid", 32'(bit_valid), 32'd0);
            end
            if (mid_cfg && c == 2) begin
                cfg_we      = 1'b1;
                cfg_pattern = 4'b1111;
                cfg_overlap = ~cur_ov;
            end else begin
                cfg_we      = 1'b0;
            end
            @(negedge clk);
        end
        chk("report_out_valid", 32'(bus.out_valid), 32'd1);
        chk("report_count", 32'(bus.out_count), 32'(exp_cnt));
        chk("report_mask", 32'(bus.out_mask), 32'(exp_mask));
        chk("report_hit", 32'(hit), 32'd0);
        got_count = 32'(bus.out_count);
        got_mask  = 32'(bus.out_mask);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_count", 32'(bus.out_count), got_count);
            chk("hold_mask", 32'(bus.out_mask), got_mask);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("after_out_valid", 32'(bus.out_valid), 32'd0);
        chk("after_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        cfg_we        = 1'b0;
        cfg_pattern   = '0;
        cfg_overlap   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        cur_pat       = 4'b1011;
        cur_ov        = 1'b1;
        got_count     = '0;
        got_mask      = '0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_a_out", 32'(a_out), 32'd0);
        chk("rst_count", 32'(bus.out_count), 32'd0);
        chk("rst_mask", 32'(bus.out_mask), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Default config, overlap; mid-word config write must be ignored; held result.
        scan(8'b1011_0110, 1'b0, 4'b0000, 1'b0, 1'b1, 5);
        chk("ovl_count", got_count, 32'd2);
        chk("ovl_mask", got_mask, 32'b0001_0010);

        scan(8'hFF, 1'b0, 4'b0000, 1'b0, 1'b0, 0);
        chk("cfg_kept_count", got_count, 32'd0);

        scan(8'b1011_0110, 1'b1, 4'b1011, 1'b0, 1'b0, 1);
        chk("novl_count", got_count, 32'd1);
        chk("novl_mask", got_mask, 32'b0001_0000);

        scan(8'h00, 1'b1, 4'b1011, 1'b1, 1'b0, 0);
        chk("nomatch_count", got_count, 32'd0);
        chk("nomatch_mask", got_mask, 32'd0);

        scan(8'hFF, 1'b1, 4'b1111, 1'b1, 1'b0, 0);
        chk("ones_count", got_count, 32'd5);
        chk("ones_mask", got_mask, 32'b0001_1111);

        scan(8'h00, 1'b1, 4'b0000, 1'b1, 1'b0, 2);
        chk("zeros_count", got_count, 32'd5);
        chk("zeros_mask", got_mask, 32'b0001_1111);

        for (int r = 0; r < 12; r++) begin
            scan(DW'($urandom), 1'b1, PW'($urandom_range(0, 15)), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Abort mid-word with reset.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_shift", 32'(bit_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_bit_valid", 32'(bit_valid), 32'd0);
        chk("abort_a_out", 32'(a_out), 32'd0);
        chk("abort_hit", 32'(hit), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_count", 32'(bus.out_count), 32'd0);
        chk("abort_mask", 32'(bus.out_mask), 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        cur_pat = 4'b1011;
        cur_ov  = 1'b1;
        @(negedge clk);
        chk("abort_rel_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < DW + 4; i++) begin
            chk("abort_no_out_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end

        scan(8'b1011_0110, 1'b0, 4'b0000, 1'b0, 1'b0, 0);
        chk("post_rst_count", got_count, 32'd2);
        chk("post_rst_mask", got_mask, 32'b0001_0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
